// File: rtl/axi4_burst_sram_slave_pkg.sv
// Shared AXI4 burst encodings, response codes, FSM states and the beat
// address stepping function used by both the read and write channels.
package axi4_burst_sram_slave_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA} rstate_e;

  // Reserved burst type 3 falls through to INCR.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [7:0]  len,
                                            input logic [2:0]  size,
                                            input logic [1:0]  burst);
    logic [31:0] step, aligned, incr, wsz;
    step    = 32'd1 << size;
    aligned = addr & ~(step - 32'd1);
    incr    = aligned + step;
    wsz     = ({24'd0, len} + 32'd1) << size;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~(wsz - 32'd1)) | (incr & (wsz - 32'd1));
      default:     next_addr = incr;
    endcase
  endfunction

endpackage

// File: rtl/axi4_burst_sram_slave_sram_1r1w.sv
// Byte-enabled write port plus registered read port; a same-cycle read of
// the word being written returns the pre-write contents.
module sram_1r1w #(
  parameter int DW   = 128,
  parameter int IDXW = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [IDXW-1:0]   i_waddr,
  input  logic [DW-1:0]     i_wdata,
  input  logic [DW/8-1:0]   i_wstrb,
  input  logic              i_re,
  input  logic [IDXW-1:0]   i_raddr,
  output logic [DW-1:0]     o_rdata
);

  localparam int DEPTH = 1 << IDXW;

  logic [DW-1:0] ram [0:DEPTH-1];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < DW/8; b++) begin
        if (i_wstrb[b]) ram[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)  o_rdata <= '0;
    else if (i_re) o_rdata <= ram[i_raddr];
  end

endmodule

// File: rtl/axi4_burst_sram_slave.sv
// AXI4 slave over a single SRAM: one outstanding write and one outstanding
// read, independent channels, FIXED/INCR/WRAP bursts.
module axi4_burst_sram_slave
  import axi4_burst_sram_slave_pkg::*;
#(
  parameter int DW = 128,
  parameter int AW = 20,
  parameter int IW = 8
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic [IW-1:0]   MEM_AWID,
  input  logic [31:0]     MEM_AWADDR,
  input  logic [7:0]      MEM_AWLEN,
  input  logic [2:0]      MEM_AWSIZE,
  input  logic [1:0]      MEM_AWBURST,
  input  logic            MEM_AWVALID,
  output logic            MEM_AWREADY,
  input  logic [DW-1:0]   MEM_WDATA,
  input  logic [DW/8-1:0] MEM_WSTRB,
  input  logic            MEM_WLAST,
  input  logic            MEM_WVALID,
  output logic            MEM_WREADY,
  output logic [IW-1:0]   MEM_BID,
  output logic [1:0]      MEM_BRESP,
  output logic            MEM_BVALID,
  input  logic            MEM_BREADY,
  input  logic [IW-1:0]   MEM_ARID,
  input  logic [31:0]     MEM_ARADDR,
  input  logic [7:0]      MEM_ARLEN,
  input  logic [2:0]      MEM_ARSIZE,
  input  logic [1:0]      MEM_ARBURST,
  input  logic            MEM_ARVALID,
  output logic            MEM_ARREADY,
  output logic [IW-1:0]   MEM_RID,
  output logic [DW-1:0]   MEM_RDATA,
  output logic [1:0]      MEM_RRESP,
  output logic            MEM_RLAST,
  output logic            MEM_RVALID,
  input  logic            MEM_RREADY
);

  localparam int LSB  = $clog2(DW/8);
  localparam int IDXW = AW - LSB;

  wstate_e       r_wstate, w_wstate_nxt;
  logic [IW-1:0] r_awid;
  logic [31:0]   r_waddr;
  logic [7:0]    r_awlen, r_wcnt;
  logic [2:0]    r_awsize;
  logic [1:0]    r_awburst;
  logic          w_we;

  rstate_e          r_rstate, w_rstate_nxt;
  logic [IW-1:0]    r_arid;
  logic [31:0]      r_raddr, w_rnext;
  logic [7:0]       r_arlen, r_rcnt;
  logic [2:0]       r_arsize;
  logic [1:0]       r_arburst;
  logic             w_re, w_rlast;
  logic [IDXW-1:0]  w_ridx;

  // ---------------- write channel ----------------
  always_comb begin
    w_wstate_nxt = r_wstate;
    MEM_AWREADY  = 1'b0;
    MEM_WREADY   = 1'b0;
    MEM_BVALID   = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        MEM_AWREADY = 1'b1;
        if (MEM_AWVALID) w_wstate_nxt = W_DATA;
      end
      W_DATA: begin
        MEM_WREADY = 1'b1;
        // WLAST or the beat count, whichever arrives first, closes the burst
        if (MEM_WVALID && (MEM_WLAST || r_wcnt == r_awlen)) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        MEM_BVALID = 1'b1;
        if (MEM_BREADY) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  assign w_we      = MEM_WREADY & MEM_WVALID & RSTn;
  assign MEM_BID   = r_awid;
  assign MEM_BRESP = RESP_OKAY;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_wstate  <= W_IDLE;
      r_awid    <= '0;
      r_waddr   <= '0;
      r_awlen   <= '0;
      r_awsize  <= '0;
      r_awburst <= '0;
      r_wcnt    <= '0;
    end else begin
      r_wstate <= w_wstate_nxt;
      if (MEM_AWREADY && MEM_AWVALID) begin
        r_awid    <= MEM_AWID;
        r_waddr   <= MEM_AWADDR;
        r_awlen   <= MEM_AWLEN;
        r_awsize  <= MEM_AWSIZE;
        r_awburst <= MEM_AWBURST;
        r_wcnt    <= '0;
      end
      if (w_we) begin
        r_waddr <= next_addr(r_waddr, r_awlen, r_awsize, r_awburst);
        r_wcnt  <= r_wcnt + 8'd1;
      end
    end
  end

  // ---------------- read channel ----------------
  assign w_rnext = next_addr(r_raddr, r_arlen, r_arsize, r_arburst);
  assign w_rlast = (r_rstate == R_DATA) && (r_rcnt == r_arlen);

  always_comb begin
    w_rstate_nxt = r_rstate;
    MEM_ARREADY  = 1'b0;
    MEM_RVALID   = 1'b0;
    w_re         = 1'b0;
    w_ridx       = w_rnext[AW-1:LSB];
    case (r_rstate)
      R_IDLE: begin
        MEM_ARREADY = 1'b1;
        w_ridx      = MEM_ARADDR[AW-1:LSB];
        if (MEM_ARVALID) begin
          w_re         = 1'b1;
          w_rstate_nxt = R_DATA;
        end
      end
      R_DATA: begin
        MEM_RVALID = 1'b1;
        // fetch the next beat on the handshake edge so beats stream without bubbles
        if (MEM_RREADY) begin
          if (w_rlast) w_rstate_nxt = R_IDLE;
          else         w_re         = 1'b1;
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  assign MEM_RID   = r_arid;
  assign MEM_RRESP = RESP_OKAY;
  assign MEM_RLAST = w_rlast;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_rstate  <= R_IDLE;
      r_arid    <= '0;
      r_raddr   <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arburst <= '0;
      r_rcnt    <= '0;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (MEM_ARREADY && MEM_ARVALID) begin
        r_arid    <= MEM_ARID;
        r_raddr   <= MEM_ARADDR;
        r_arlen   <= MEM_ARLEN;
        r_arsize  <= MEM_ARSIZE;
        r_arburst <= MEM_ARBURST;
        r_rcnt    <= '0;
      end else if (MEM_RVALID && MEM_RREADY && !w_rlast) begin
        r_raddr <= w_rnext;
        r_rcnt  <= r_rcnt + 8'd1;
      end
    end
  end

  sram_1r1w #(.DW(DW), .IDXW(IDXW)) i_sram (
    .i_clk   (CLK),
    .i_rst_n (RSTn),
    .i_we    (w_we),
    .i_waddr (r_waddr[AW-1:LSB]),
    .i_wdata (MEM_WDATA),
    .i_wstrb (MEM_WSTRB),
    .i_re    (w_re),
    .i_raddr (w_ridx),
    .o_rdata (MEM_RDATA)
  );

endmodule

// File: tb/tb_axi4_burst_sram_slave.sv
// Randomized AXI4 burst traffic against a word-array model of the SRAM slave.
module tb_axi4_burst_sram_slave;

  logic         CLK = 1'b0;
  logic         RSTn = 1'b0;
  logic [7:0]   MEM_AWID, MEM_ARID, MEM_BID, MEM_RID;
  logic [31:0]  MEM_AWADDR, MEM_ARADDR;
  logic [7:0]   MEM_AWLEN, MEM_ARLEN;
  logic [2:0]   MEM_AWSIZE, MEM_ARSIZE;
  logic [1:0]   MEM_AWBURST, MEM_ARBURST, MEM_BRESP, MEM_RRESP;
  logic         MEM_AWVALID, MEM_AWREADY, MEM_WLAST, MEM_WVALID, MEM_WREADY;
  logic         MEM_BVALID, MEM_BREADY, MEM_ARVALID, MEM_ARREADY;
  logic         MEM_RLAST, MEM_RVALID, MEM_RREADY;
  logic [127:0] MEM_WDATA, MEM_RDATA;
  logic [15:0]  MEM_WSTRB;

  axi4_burst_sram_slave dut (
    .CLK(CLK), .RSTn(RSTn),
    .MEM_AWID(MEM_AWID), .MEM_AWADDR(MEM_AWADDR), .MEM_AWLEN(MEM_AWLEN),
    .MEM_AWSIZE(MEM_AWSIZE), .MEM_AWBURST(MEM_AWBURST), .MEM_AWVALID(MEM_AWVALID),
    .MEM_AWREADY(MEM_AWREADY), .MEM_WDATA(MEM_WDATA), .MEM_WSTRB(MEM_WSTRB),
    .MEM_WLAST(MEM_WLAST), .MEM_WVALID(MEM_WVALID), .MEM_WREADY(MEM_WREADY),
    .MEM_BID(MEM_BID), .MEM_BRESP(MEM_BRESP), .MEM_BVALID(MEM_BVALID),
    .MEM_BREADY(MEM_BREADY), .MEM_ARID(MEM_ARID), .MEM_ARADDR(MEM_ARADDR),
    .MEM_ARLEN(MEM_ARLEN), .MEM_ARSIZE(MEM_ARSIZE), .MEM_ARBURST(MEM_ARBURST),
    .MEM_ARVALID(MEM_ARVALID), .MEM_ARREADY(MEM_ARREADY), .MEM_RID(MEM_RID),
    .MEM_RDATA(MEM_RDATA), .MEM_RRESP(MEM_RRESP), .MEM_RLAST(MEM_RLAST),
    .MEM_RVALID(MEM_RVALID), .MEM_RREADY(MEM_RREADY)
  );

  always #5 CLK = ~CLK;

  logic [127:0] ref_mem [0:65535];
  logic [127:0] wd_q[$];
  logic [15:0]  ws_q[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Word touched by beat i, derived from the burst definition directly.
  function automatic int beat_word(input logic [31:0] a, input int len, input int size,
                                   input int burst, input int i);
    longint unsigned step, al, ws, base, ba;
    step = 64'd1 << size;
    al   = {32'd0, a} - ({32'd0, a} % step);
    if (burst == 0) ba = {32'd0, a};
    else if (burst == 2) begin
      ws   = 64'(len + 1) * step;
      base = al - (al % ws);
      ba   = (i == 0) ? {32'd0, a} : base + ((al - base + 64'(i) * step) % ws);
    end else ba = (i == 0) ? {32'd0, a} : al + 64'(i) * step;
    return int'((ba >> 4) % 65536);
  endfunction

  task automatic fill_rand(input int n);
    wd_q.delete(); ws_q.delete();
    for (int i = 0; i < n; i++) begin
      wd_q.push_back({$urandom, $urandom, $urandom, $urandom});
      ws_q.push_back(16'($urandom));
    end
  endtask

  task automatic wait_sig(input string tag, ref logic s);
    int cyc = 0;
    while (s !== 1'b1 && cyc < 200) begin @(posedge CLK); #1; cyc++; end
    if (cyc >= 200) chk(tag, 0, 1);
  endtask

  task automatic axi_write(input logic [7:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input int early,
                           input bit nolast, input int bhold);
    int nb, w;
    MEM_AWID = id; MEM_AWADDR = addr; MEM_AWLEN = 8'(len);
    MEM_AWSIZE = 3'(size); MEM_AWBURST = 2'(burst); MEM_AWVALID = 1'b1;
    wait_sig("aw_timeout", MEM_AWREADY);
    @(posedge CLK); #1; MEM_AWVALID = 1'b0;
    nb = (early >= 0) ? early + 1 : len + 1;
    for (int i = 0; i < nb; i++) begin
      if ($urandom_range(0, 3) == 0) begin MEM_WVALID = 1'b0; @(posedge CLK); #1; end
      MEM_WDATA = wd_q[i]; MEM_WSTRB = ws_q[i];
      MEM_WLAST = (i == nb - 1) && (early >= 0 || !nolast);
      MEM_WVALID = 1'b1;
      wait_sig("w_timeout", MEM_WREADY);
      @(posedge CLK); #1;
      w = beat_word(addr, len, size, burst, i);
      for (int b = 0; b < 16; b++) if (ws_q[i][b]) ref_mem[w][8*b +: 8] = wd_q[i][8*b +: 8];
    end
    MEM_WVALID = 1'b0; MEM_WLAST = 1'b0;
    chk("w_closed", MEM_WREADY, 0);
    wait_sig("b_timeout", MEM_BVALID);
    chk("bid", MEM_BID, id);
    chk("bresp", MEM_BRESP, 0);
    MEM_AWVALID = (bhold > 0);
    for (int k = 0; k < bhold; k++) begin
      chk("bhold_valid", MEM_BVALID, 1);
      chk("bhold_id", MEM_BID, id);
      chk("bhold_noaw", MEM_AWREADY, 0);
      @(posedge CLK); #1;
    end
    MEM_AWVALID = 1'b0; MEM_BREADY = 1'b1;
    @(posedge CLK); #1; MEM_BREADY = 1'b0;
    chk("b_done", MEM_BVALID, 0);
    chk("aw_ready_again", MEM_AWREADY, 1);
  endtask

  task automatic axi_read(input logic [7:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst, input bit bp);
    logic [127:0] exp_q[$];
    int beat, cyc;
    for (int i = 0; i <= len; i++) exp_q.push_back(ref_mem[beat_word(addr, len, size, burst, i)]);
    MEM_ARID = id; MEM_ARADDR = addr; MEM_ARLEN = 8'(len);
    MEM_ARSIZE = 3'(size); MEM_ARBURST = 2'(burst); MEM_ARVALID = 1'b1;
    wait_sig("ar_timeout", MEM_ARREADY);
    @(posedge CLK); #1; MEM_ARVALID = 1'b0;
    chk("rvalid_rise", MEM_RVALID, 1);
    beat = 0; cyc = 0;
    while (beat <= len && cyc < 400) begin
      MEM_RREADY = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!bp) chk("r_nobubble", MEM_RVALID, 1);
      if (MEM_RVALID && MEM_RREADY) begin
        chk("rdata", MEM_RDATA, exp_q[beat]);
        chk("rlast", MEM_RLAST, 128'(beat == len));
        chk("rid", MEM_RID, id);
        chk("rresp", MEM_RRESP, 0);
        beat++;
      end else if (MEM_RVALID) begin
        chk("rhold_data", MEM_RDATA, exp_q[beat]);
        chk("rhold_last", MEM_RLAST, 128'(beat == len));
      end
      @(posedge CLK); #1; cyc++;
    end
    MEM_RREADY = 1'b0;
    if (beat <= len) chk("r_timeout", 0, 1);
    chk("r_done", MEM_RVALID, 0);
    chk("ar_ready_again", MEM_ARREADY, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [127:0] v, oldv, newv;
    int len, size, burst, early;
    logic [31:0] addr;
    bit nolast;
    MEM_AWID = 0; MEM_AWADDR = 0; MEM_AWLEN = 0; MEM_AWSIZE = 0; MEM_AWBURST = 0;
    MEM_AWVALID = 0; MEM_WDATA = 0; MEM_WSTRB = 0; MEM_WLAST = 0; MEM_WVALID = 0;
    MEM_BREADY = 0; MEM_ARID = 0; MEM_ARADDR = 0; MEM_ARLEN = 0; MEM_ARSIZE = 0;
    MEM_ARBURST = 0; MEM_ARVALID = 0; MEM_RREADY = 0;
    for (int i = 0; i < 128; i++) begin
      v = (i < 4) ? 128'(8'hA0 + i) : {$urandom, $urandom, $urandom, $urandom};
      ref_mem[i] = v;
      dut.i_sram.ram[i] = v;
    end

    repeat (3) @(posedge CLK); #1;
    chk("rst_awready", MEM_AWREADY, 1);
    chk("rst_arready", MEM_ARREADY, 1);
    chk("rst_wready", MEM_WREADY, 0);
    chk("rst_bvalid", MEM_BVALID, 0);
    chk("rst_rvalid", MEM_RVALID, 0);
    chk("rst_rlast", MEM_RLAST, 0);
    chk("rst_bid", MEM_BID, 0);
    chk("rst_rid", MEM_RID, 0);
    chk("rst_bresp", MEM_BRESP, 0);
    chk("rst_rresp", MEM_RRESP, 0);
    chk("rst_rdata", MEM_RDATA, 0);
    RSTn = 1'b1;
    @(posedge CLK); #1;

    axi_read(8'h33, 32'h0, 3, 4, 1, 0);          // INCR words 0..3
    axi_read(8'h34, 32'h30, 3, 4, 2, 0);         // WRAP words 3,0,1,2
    axi_read(8'h35, 32'h20, 3, 4, 0, 0);         // FIXED word 2 x4

    oldv = ref_mem[1];
    wd_q.delete(); ws_q.delete();
    wd_q.push_back(128'h0123_4567_89AB_CDEF_1122_3344_5566_7788);
    ws_q.push_back(16'h00FF);
    axi_write(8'h5A, 32'h8000_0010, 0, 4, 1, -1, 0, 0);
    chk("w1_lo", dut.i_sram.ram[1][63:0], 64'h1122_3344_5566_7788);
    chk("w1_hi", dut.i_sram.ram[1][127:64], oldv[127:64]);
    axi_read(8'h36, 32'h10, 0, 4, 1, 0);

    fill_rand(4);
    axi_write(8'h77, 32'h200, 3, 4, 1, -1, 0, 5);
    axi_read(8'h78, 32'h200, 3, 4, 1, 1);

    // write beat and read address hit word 5 on the same edge
    oldv = ref_mem[5];
    newv = {$urandom, $urandom, $urandom, $urandom};
    MEM_AWID = 8'h11; MEM_AWADDR = 32'h50; MEM_AWLEN = 0; MEM_AWSIZE = 4; MEM_AWBURST = 1;
    MEM_AWVALID = 1'b1;
    wait_sig("coll_aw_timeout", MEM_AWREADY);
    @(posedge CLK); #1; MEM_AWVALID = 1'b0;
    MEM_WDATA = newv; MEM_WSTRB = 16'hFFFF; MEM_WLAST = 1'b1; MEM_WVALID = 1'b1;
    MEM_ARID = 8'h12; MEM_ARADDR = 32'h50; MEM_ARLEN = 0; MEM_ARSIZE = 4; MEM_ARBURST = 1;
    MEM_ARVALID = 1'b1;
    chk("coll_both_ready", {MEM_WREADY, MEM_ARREADY}, 2'b11);
    @(posedge CLK); #1;
    MEM_WVALID = 1'b0; MEM_WLAST = 1'b0; MEM_ARVALID = 1'b0;
    chk("coll_rvalid", MEM_RVALID, 1);
    chk("coll_old", MEM_RDATA, oldv);
    ref_mem[5] = newv;
    MEM_RREADY = 1'b1; MEM_BREADY = 1'b1;
    chk("coll_bvalid", MEM_BVALID, 1);
    @(posedge CLK); #1;
    MEM_RREADY = 1'b0; MEM_BREADY = 1'b0;
    axi_read(8'h13, 32'h50, 0, 4, 1, 0);

    // reset lands mid-burst after two beats have been written
    fill_rand(4);
    MEM_AWID = 8'h21; MEM_AWADDR = 32'h80; MEM_AWLEN = 3; MEM_AWSIZE = 4; MEM_AWBURST = 1;
    MEM_AWVALID = 1'b1;
    wait_sig("rst_aw_timeout", MEM_AWREADY);
    @(posedge CLK); #1; MEM_AWVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      MEM_WDATA = wd_q[i]; MEM_WSTRB = 16'hFFFF; MEM_WVALID = 1'b1;
      chk("rst_beat_ready", MEM_WREADY, 1);
      @(posedge CLK); #1;
      ref_mem[8 + i] = wd_q[i];
    end
    MEM_WVALID = 1'b0; RSTn = 1'b0;
    @(posedge CLK); #1;
    chk("midrst_awready", MEM_AWREADY, 1);
    chk("midrst_wready", MEM_WREADY, 0);
    chk("midrst_bvalid", MEM_BVALID, 0);
    RSTn = 1'b1;
    @(posedge CLK); #1;
    axi_read(8'h22, 32'h80, 3, 4, 1, 0);

    for (int it = 0; it < 40; it++) begin
      burst = $urandom_range(0, 3);
      size  = $urandom_range(0, 4);
      if (burst == 2) len = (2 << $urandom_range(0, 3)) - 1;
      else            len = $urandom_range(0, 15);
      addr  = 32'($urandom_range(0, 1023)) | (32'($urandom_range(0, 1)) << 31);
      early = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
      nolast = (early < 0) && ($urandom_range(0, 5) == 0);
      fill_rand(len + 1);
      axi_write(8'($urandom), addr, len, size, burst, early, nolast, $urandom_range(0, 2));
      axi_read(8'($urandom), addr, len, size, burst, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1)
        axi_read(8'($urandom), 32'($urandom_range(0, 1023)), $urandom_range(0, 15), 4, 1, 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/axi4_burst_sram_slave.md
Name: axi4_burst_sram_slave

Overview:
- AXI4 full slave backed by a single on-chip SRAM word array.
- Serves the core's 128-bit memory channel in simulation and FPGA bring-up.
- Supports FIXED, INCR and WRAP bursts, with one outstanding write and one outstanding read; the read and write paths are independent.
- Memory contents are preloadable by hierarchical access to instance i_sram, array ram.

Parameters:
- DW, 128, data width in bits; a power of two, at least 32.
- AW, 20, byte-address bits decoded; depth = 2^AW/(DW/8) words (65536 at defaults).
- IW, 8, ID width.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RSTn  in  1  reset, synchronous, active-low.
- MEM_AWID  in  IW  write ID
- MEM_AWADDR  in  32  write byte address
- MEM_AWLEN  in  8  beats-1
- MEM_AWSIZE  in  3  log2 bytes/beat
- MEM_AWBURST  in  2  0 FIXED, 1 INCR, 2 WRAP
- MEM_AWVALID  in  1
- MEM_AWREADY  out  1
- MEM_WDATA  in  DW
- MEM_WSTRB  in  DW/8  byte enables
- MEM_WLAST  in  1
- MEM_WVALID  in  1
- MEM_WREADY  out  1
- MEM_BID  out  IW
- MEM_BRESP  out  2
- MEM_BVALID  out  1
- MEM_BREADY  in  1
- MEM_ARID  in  IW
- MEM_ARADDR  in  32
- MEM_ARLEN  in  8
- MEM_ARSIZE  in  3
- MEM_ARBURST  in  2
- MEM_ARVALID  in  1
- MEM_ARREADY  out  1
- MEM_RID  out  IW
- MEM_RDATA  out  DW
- MEM_RRESP  out  2
- MEM_RLAST  out  1
- MEM_RVALID  out  1
- MEM_RREADY  in  1

Behaviour:
- Addressing:
  - Word index = addr[AW-1:log2(DW/8)]; address bits at and above AW are ignored, so 0x8000_0000 aliases to word 0.
  - Next beat address:
    - FIXED: unchanged.
    - INCR: (addr aligned down to 2^size) + 2^size.
    - WRAP: the INCR result wrapped within the (len+1)*2^size aligned window; len must be 1, 3, 7 or 15.
    - Reserved burst type 3 behaves as INCR.
  - Index arithmetic is modulo depth.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: AWREADY=1. On AWVALID, latch id/addr/len/size/burst, clear beat counter, go to W_DATA.
  - W_DATA: WREADY=1. Each WVALID beat writes the bytes enabled by WSTRB into the addressed word, then advances address and counter.
    - The beat with WLAST=1, or counter==len, whichever comes first, ends the burst and moves to W_RESP.
    - Extra beats are never accepted.
  - W_RESP: BVALID=1, BID=latched id, BRESP=0 (OKAY). Held stable until BREADY, then back to W_IDLE.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: ARREADY=1. On ARVALID, latch fields and register RDATA from the first word.
  - RVALID rises the cycle after the AR handshake.
  - R_DATA: RVALID=1, RID=latched id, RRESP=0, RLAST=1 on beat len.
  - On RVALID&RREADY the next beat's word is registered on the same edge, giving back-to-back beats with no bubble.
  - RVALID, RDATA and RLAST are held while RREADY=0.
  - After the last handshake, return to R_IDLE; ARREADY is high the next cycle.
  - RDATA is always the full word; narrow reads return the whole word.
- Read/write collision on the same word in the same cycle: read returns the pre-write contents.
- Reset (RSTn=0 at an edge): both FSMs go to IDLE, abandoning any burst in flight.
  - Outputs: AWREADY=1, ARREADY=1, WREADY=0, BVALID=0, RVALID=0, RLAST=0, BID/RID/BRESP/RRESP=0, RDATA=0.
  - Memory contents are not reset.

Decomposition:
- Shared package: burst encodings FIXED/INCR/WRAP, response codes OKAY/SLVERR, and a next-beat-address function.
- One sub-module, sram_1r1w: instance i_sram, reg array ram[0:depth-1] of DW bits, byte-enabled write port and registered read port.
- The array must stay hierarchically writable for testbench preload.

Test Plan:
- Single write: AW 0x8000_0010, len 0, size 4, INCR; WDATA 0x…1122_3344…, WSTRB 0x00FF.
  - Only the low 8 bytes of word 1 change.
  - BVALID, BID=AWID, BRESP=0 after WLAST.
- INCR read: ARADDR 0x0, len 3, RREADY=1, preload words 0-3 = 0xA0..0xA3.
  - Four beats with RDATA 0xA0..0xA3 on consecutive cycles.
  - RLAST only on beat 4; RID=ARID.
- WRAP read: ARADDR 0x30, len 3, size 4 → words 3,0,1,2. FIXED len 3 at 0x20 → word 2 four times.
- Backpressure: hold BREADY=0 for 5 cycles and toggle RREADY.
  - BVALID/BID and RVALID/RDATA stay stable.
  - No new AW is accepted before B completes.
- Concurrent: write burst to word 5 while reading word 5 in the same cycle → read returns the old value; a subsequent read returns the new value.
- Reset mid-burst: drop RSTn during W_DATA beat 2 → AWREADY=1, WREADY=0, BVALID=0 next cycle; beats already written persist.
